// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide unit with internal HI/LO registers.
//   Multiply uses radix-2 Booth recoding (WIDTH steps). Divide uses a restoring
//   algorithm on operand magnitudes (WIDTH steps) followed by one sign-fix cycle.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   mult_start          1-cycle pulse, start signed a_in * b_in (wins over div_start)
//   div_start           1-cycle pulse, start signed a_in / b_in
//   a_in, b_in          operands, sampled only on the start edge while idle
//   hi_out, lo_out      HI/LO registers (product high/low, or remainder/quotient)
//   busy                high in every state except IDLE
//   done                1-cycle pulse, HI/LO valid in the same cycle
//   div_zero            divide-by-zero flag, meaningful only while done=1
// Build option: define DIV_BY_ZERO_TRAP_EN to short-circuit a zero divisor
//   (done one edge after the start edge, div_zero=1, HI/LO untouched).
//   Without it div_zero is 0 and a zero divisor runs the full divide.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DIV_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // Booth A, one extra bit to absorb -M of the most negative M
  logic [WIDTH-1:0] q_q, q_d;         // Booth Q / divide dividend-then-quotient
  logic             q_m1_q, q_m1_d;   // Booth Q-1
  logic [WIDTH-1:0] m_q, m_d;         // Booth M / divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes; the most negative value maps onto itself, read as unsigned.
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_abs = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_abs = b_in[WIDTH-1] ? -b_in : b_in;

  // One Booth step: add/subtract M per {Q0,Q-1}, then arithmetic shift of {A,Q,Q-1}.
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_a;
  logic [WIDTH-1:0] booth_q;

  always_comb begin
    booth_sum = acc_q;
    case ({q_q[0], q_m1_q})
      2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
      2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
      default: booth_sum = acc_q;
    endcase
  end

  assign booth_a = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_q = {booth_sum[0], q_q[WIDTH-1:1]};

  // One restoring step. The shifted remainder needs WIDTH+1 bits for the compare;
  // when the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem;

  assign div_shift = {rem_q, q_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_diff  = div_shift[WIDTH-1:0] - m_q;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q_m1_d  = q_m1_q;
    m_d     = m_q;
    rem_d   = rem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          acc_d   = '0;
          q_d     = b_in;
          q_m1_d  = 1'b0;
          m_d     = a_in;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = S_MULT;
        end else if (div_start) begin
          m_d     = b_abs;
          q_d     = a_abs;
          rem_d   = '0;
          sa_d    = a_in[WIDTH-1];
          sb_d    = b_in[WIDTH-1];
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = S_DIV;
`ifdef DIV_BY_ZERO_TRAP_EN
          // Zero divisor skips the iterations; passing through DIV_FIX with the
          // flag set gives done one edge after the start edge and leaves HI/LO alone.
          if (b_in == '0) begin
            dz_d    = 1'b1;
            state_d = S_DIV_FIX;
          end
`endif
        end
      end

      S_MULT: begin
        acc_d  = booth_a;
        q_d    = booth_q;
        q_m1_d = q_q[0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          hi_d    = booth_a[WIDTH-1:0];
          lo_d    = booth_q;
          state_d = S_DONE;
        end
      end

      S_DIV: begin
        rem_d = div_rem;
        q_d   = {q_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DIV_FIX;
        end
      end

      S_DIV_FIX: begin
        if (!dz_q) begin
          lo_d = (sa_q ^ sb_q) ? -q_q : q_q;
          hi_d = sa_q ? -rem_q : rem_q;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      m_q     <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      m_q     <= m_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

`ifdef DIV_BY_ZERO_TRAP_EN
  assign div_zero = (state_q == S_DONE) && dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit.
//   A transaction-level model (signed 64-bit arithmetic plus a latency countdown)
//   predicts busy/done/div_zero/HI/LO every cycle; directed cases pin literal results.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .mult_start(mult_start),
    .div_start (div_start),
    .a_in      (a_in),
    .b_in      (b_in),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Returns {HI, LO} = {remainder, quotient}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] qq, rr;
    if (b == 32'h0) begin
      rr = a;
      qq = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qq = q[31:0];
      rr = r[31:0];
    end
    return {rr, qq};
  endfunction

  // ---------------- cycle model ----------------
  bit          m_busy, m_done, m_dz, p_dz;
  int          m_left;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [63:0] m_res;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0; m_dz = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
      end
    end else if (mult_start) begin
      m_res = ref_mult(a_in, b_in);
      p_hi = m_res[63:32]; p_lo = m_res[31:0]; p_dz = 1'b0;
      m_left = 32; m_busy = 1'b1;
    end else if (div_start) begin
      m_res = ref_div(a_in, b_in);
      p_hi = m_res[63:32]; p_lo = m_res[31:0]; p_dz = 1'b0;
      m_left = 33; m_busy = 1'b1;
`ifdef DIV_BY_ZERO_TRAP_EN
      if (b_in == 32'h0) begin
        p_hi = m_hi; p_lo = m_lo; p_dz = 1'b1; m_left = 1;
      end
`endif
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clock) begin
    if (armed) begin
      chk("busy",     {31'b0, busy},     {31'b0, m_busy});
      chk("done",     {31'b0, done},     {31'b0, m_done});
      chk("div_zero", {31'b0, div_zero}, {31'b0, m_done & m_dz});
      chk("hi_out",   hi_out, m_hi);
      chk("lo_out",   lo_out, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Pulses the start(s), then waits (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input bit dm, input bit dd, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output int lat);
    @(negedge clock);
    mult_start = dm; div_start = dd; a_in = a; b_in = b;
    @(negedge clock);
    mult_start = 1'b0; div_start = 1'b0; a_in = $urandom; b_in = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      if (noise) begin
        mult_start = ($urandom_range(0, 7) == 0);
        div_start  = ($urandom_range(0, 7) == 0);
        a_in = $urandom; b_in = $urandom;
      end
      @(negedge clock);
      lat++;
    end
    mult_start = 1'b0; div_start = 1'b0;
    chk("done_seen", {31'b0, done}, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int lat, exp_lat, dones;
  logic [31:0] a, b, t5_hi, t5_lo;
  bit dm, dd;

  initial begin
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    armed = 1'b1;

    // reset state
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);

    // T1
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd32);
    chk("t1_hi", hi_out, 32'hFFFF_FFFF);
    chk("t1_lo", lo_out, 32'hFFFF_FFEB);

    // T2
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    chk("t2_hi", hi_out, 32'h4000_0000);
    chk("t2_lo", lo_out, 32'h0000_0000);

    // T3
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    chk("t3_lat", 32'(lat), 32'd33);
    chk("t3_lo", lo_out, 32'hFFFF_FFFD);
    chk("t3_hi", hi_out, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    chk("t3_ovf_lo", lo_out, 32'h8000_0000);
    chk("t3_ovf_hi", hi_out, 32'h0);

    // T4
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, lat);
`ifdef DIV_BY_ZERO_TRAP_EN
    chk("t4_lat", 32'(lat), 32'd1);
    chk("t4_dz", {31'b0, div_zero}, 32'h1);
    chk("t4_hi", hi_out, 32'h0);
    chk("t4_lo", lo_out, 32'h8000_0000);
`else
    chk("t4_lat", 32'(lat), 32'd33);
    chk("t4_dz", {31'b0, div_zero}, 32'h0);
    chk("t4_hi", hi_out, 32'd5);
    chk("t4_lo", lo_out, 32'hFFFF_FFFF);
`endif

    // T5: simultaneous starts, plus a mult_start at edge 10 that must be ignored
    @(negedge clock);
    mult_start = 1'b1; div_start = 1'b1; a_in = 32'd6; b_in = 32'd7;
    @(negedge clock);
    mult_start = 1'b0; div_start = 1'b0;
    dones = 0; exp_lat = -1; t5_hi = '0; t5_lo = '0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin
        dones++;
        if (exp_lat < 0) begin exp_lat = i; t5_hi = hi_out; t5_lo = lo_out; end
      end
      mult_start = (i == 9);
      if (i == 9) begin a_in = 32'd100; b_in = 32'd100; end
      @(negedge clock);
    end
    mult_start = 1'b0;
    chk("t5_dones", 32'(dones), 32'd1);
    chk("t5_lat", 32'(exp_lat), 32'd32);
    chk("t5_lo", t5_lo, 32'd42);
    chk("t5_hi", t5_hi, 32'd0);

    // T6: reset at edge 15 of a divide
    @(negedge clock);
    div_start = 1'b1; a_in = 32'd100; b_in = 32'd7;
    @(negedge clock);
    div_start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6_busy", {31'b0, busy}, 32'h0);
    chk("t6_hi", hi_out, 32'h0);
    chk("t6_lo", lo_out, 32'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clock);
    end
    chk("t6_no_done", 32'(dones), 32'd0);
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, lat);
    chk("t6_lo", lo_out, 32'd12);
    chk("t6_hi", hi_out, 32'd0);

    // Randomized back-to-back operations with spurious starts while busy
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 2))
        0:       begin dm = 1'b1; dd = 1'b0; end
        1:       begin dm = 1'b0; dd = 1'b1; end
        default: begin dm = 1'b1; dd = 1'b1; end
      endcase
      a = pick();
      b = pick();
      exp_lat = dm ? 32 : 33;
`ifdef DIV_BY_ZERO_TRAP_EN
      if (!dm && b == 32'h0) exp_lat = 1;
`endif
      run_op(dm, dd, a, b, 1'b1, lat);
      chk("rand_lat", 32'(lat), 32'(exp_lat));
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
